// File: rtl/psram_pkg.sv
// Shared definitions for the asynchronous CellularRAM (PSRAM) controller.
// Contents:
//   psram_state_e   controller state encoding (IDLE/READ/WRITE/RECOV)
//   *_50MHZ/*_100MHZ default access/recovery cycle counts for tAA/tWC = 70 ns parts
//   max3            helper used to size the shared cycle counter
package psram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RECOV = 2'd3
  } psram_state_e;

  // 70 ns access time: 4 cycles at 20 ns, 8 cycles at 10 ns.
  localparam int RD_CYCLES_50MHZ   = 4;
  localparam int WR_CYCLES_50MHZ   = 4;
  localparam int REC_CYCLES_50MHZ  = 1;
  localparam int RD_CYCLES_100MHZ  = 8;
  localparam int WR_CYCLES_100MHZ  = 8;
  localparam int REC_CYCLES_100MHZ = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/psram_cycle_timer.sv
// Loadable down-counter with zero flag; times each access and recovery phase.
// Ports:
//   clk, rst   clock, synchronous active-high reset (count -> 0)
//   load       load load_val this cycle (takes priority over counting)
//   load_val   value to load (phase length minus one)
//   zero       count is currently zero (phase ends at this edge)
module psram_cycle_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/psram_async_ctrl.sv
// Asynchronous-mode CellularRAM controller. Accepts one valid/ready request at
// a time, runs a fixed-length read or write strobe window, then a recovery gap.
// All memory strobes and the response strobe come straight from flops.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_addr         1=write / 0=read, word address
//   req_wdata, req_be        write data and byte enables {upper,lower}
//   rsp_valid                1-cycle pulse: read data valid or write retired
//   rsp_rdata                last read data, held until next read completes
//   mem_addr                 zero-extended latched address
//   mem_data                 bidirectional data bus, driven only for writes
//   mem_clk/adv_n/cre        tied low for asynchronous mode
//   mem_ce_n/oe_n/we_n       chip, output and write enables
//   mem_ub_n/lb_n            byte lane enables
//   mem_wait                 unused in asynchronous mode
module psram_async_ctrl
  import psram_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int MEM_ADDR_W = 26,
  parameter int DATA_W     = 16,
  parameter int RD_CYCLES  = 4,
  parameter int WR_CYCLES  = 4,
  parameter int REC_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0]     mem_data,
  output logic                  mem_clk,
  output logic                  mem_adv_n,
  output logic                  mem_cre,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic                  mem_ub_n,
  output logic                  mem_lb_n,
  input  logic                  mem_wait
);

  localparam int MAX_CYC = max3(RD_CYCLES, WR_CYCLES, REC_CYCLES);
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYCLES - 1);

  if (MEM_ADDR_W < ADDR_W) begin : g_bad_addr_w
    $error("psram_async_ctrl: MEM_ADDR_W must be >= ADDR_W");
  end
  if (RD_CYCLES < 1 || WR_CYCLES < 1 || REC_CYCLES < 1) begin : g_bad_cycles
    $error("psram_async_ctrl: RD/WR/REC_CYCLES must all be >= 1");
  end
  if (DATA_W != 16) begin : g_bad_data_w
    $error("psram_async_ctrl: DATA_W must be 16 (two byte lanes)");
  end

  psram_state_e          state_q,     state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [MEM_ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0]     wdata_q,     wdata_d;
  logic                  ce_n_q,      ce_n_d;
  logic                  oe_n_q,      oe_n_d;
  logic                  we_n_q,      we_n_d;
  logic                  ub_n_q,      ub_n_d;
  logic                  lb_n_q,      lb_n_d;
  logic                  drive_en_q,  drive_en_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;

  psram_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    drive_en_d  = drive_en_q;
    timer_load  = 1'b0;
    timer_val   = '0;

    case (state_q)
      ST_IDLE: begin
        // Ready rises on the first cycle after reset as well as after RECOV.
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = MEM_ADDR_W'(req_addr);
          wdata_d     = req_wdata;
          ce_n_d      = 1'b0;
          timer_load  = 1'b1;
          if (req_we) begin
            state_d    = ST_WRITE;
            timer_val  = WR_LOAD;
            we_n_d     = 1'b0;
            ub_n_d     = ~req_be[1];
            lb_n_d     = ~req_be[0];
            drive_en_d = 1'b1;
          end else begin
            // Reads always fetch both lanes; byte enables are write-only.
            state_d    = ST_READ;
            timer_val  = RD_LOAD;
            oe_n_d     = 1'b0;
            ub_n_d     = 1'b0;
            lb_n_d     = 1'b0;
          end
        end
      end
      ST_READ: begin
        if (timer_zero) begin
          rsp_rdata_d = mem_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_RECOV;
          timer_load  = 1'b1;
          timer_val   = REC_LOAD;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          ub_n_d      = 1'b1;
          lb_n_d      = 1'b1;
        end
      end
      ST_WRITE: begin
        if (timer_zero) begin
          // Bus stays driven into the first RECOV cycle for data hold.
          rsp_valid_d = 1'b1;
          state_d     = ST_RECOV;
          timer_load  = 1'b1;
          timer_val   = REC_LOAD;
          ce_n_d      = 1'b1;
          we_n_d      = 1'b1;
          ub_n_d      = 1'b1;
          lb_n_d      = 1'b1;
        end
      end
      ST_RECOV: begin
        drive_en_d = 1'b0;
        if (timer_zero) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      drive_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      drive_en_q  <= drive_en_d;
      wdata_q     <= wdata_d;
    end
  end

  assign mem_data  = drive_en_q ? wdata_q : 'z;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_ub_n  = ub_n_q;
  assign mem_lb_n  = lb_n_q;
  assign mem_clk   = 1'b0;
  assign mem_adv_n = 1'b0;
  assign mem_cre   = 1'b0;

  // WAIT has no meaning in asynchronous mode.
  logic unused_mem_wait;
  assign unused_mem_wait = mem_wait;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Directed bench for psram_async_ctrl with a small async PSRAM model
// (70 ns read access, lane writes while CE#/WE# are low). A released bus
// reads back as 16'hFFFF through pullups.
`timescale 1ns/1ps
module tb_psram_async_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        mem_wait;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [25:0] mem_addr;
  wire  [15:0] mem_data;
  logic        mem_clk, mem_adv_n, mem_cre;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  psram_async_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_clk   (mem_clk),
    .mem_adv_n (mem_adv_n),
    .mem_cre   (mem_cre),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .mem_ub_n  (mem_ub_n),
    .mem_lb_n  (mem_lb_n),
    .mem_wait  (mem_wait)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [0:255];
  logic        oe_dly_n = 1'b1;
  logic        mem_drive;
  logic [15:0] mem_out;

  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup pu_i (mem_data[gi]);
  end

  always @(mem_oe_n) oe_dly_n <= #70 mem_oe_n;

  assign mem_drive = !mem_oe_n && !oe_dly_n && !mem_ce_n && mem_we_n;
  assign mem_out   = mem[mem_addr[7:0]];
  assign mem_data  = mem_drive ? mem_out : 16'bz;

  always @(negedge clk) begin
    if (!mem_ce_n && !mem_we_n) begin
      if (!mem_ub_n) mem[mem_addr[7:0]][15:8] = mem_data[15:8];
      if (!mem_lb_n) mem[mem_addr[7:0]][7:0]  = mem_data[7:0];
    end
  end

  // Wait for ready, present a request, return #1 after the accept edge.
  task automatic start_req(input logic we, input logic [23:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 24'hFF_FFFF;
    req_wdata = 16'h5555;
    req_be    = 2'b10;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b required 0", req_ready);
    end
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 11111",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n});
    end
    checks++;
    if (mem_data !== 16'hFFFF) begin
      errors++; $display("FAIL reset_bus_released: got %h required ffff", mem_data);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rsp: got valid=%b rdata=%h required 0/0000", rsp_valid, rsp_rdata);
    end
    checks++;
    if (mem_addr !== 26'h0) begin
      errors++; $display("FAIL reset_addr: got %h required 0", mem_addr);
    end
    checks++;
    if ({mem_clk, mem_adv_n, mem_cre} !== 3'b000) begin
      errors++; $display("FAIL const_pins: got %b required 000", {mem_clk, mem_adv_n, mem_cre});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b required 1", req_ready);
    end
  endtask

  task automatic test_write();
    int we_low = 0, data_cnt = 0, rsp_cnt = 0, rsp_cyc = 0, rdy_cyc = 0;
    int lanes_bad = 0, oe_low = 0, addr_bad = 0;
    start_req(1'b1, 24'h00_0123, 16'hBEEF, 2'b11);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c <= 6 && mem_addr !== 26'h000_0123) addr_bad++;
      if (!mem_we_n) begin
        we_low++;
        if (mem_ub_n || mem_lb_n || mem_ce_n) lanes_bad++;
      end
      if (!mem_oe_n) oe_low++;
      if (mem_data === 16'hBEEF) data_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = c; end
      if (req_ready && rdy_cyc == 0) rdy_cyc = c;
    end
    checks++;
    if (addr_bad != 0) begin
      errors++; $display("FAIL wr_mem_addr: %0d cycles off, last %h required 0000123", addr_bad, mem_addr);
    end
    checks++;
    if (we_low != 4) begin
      errors++; $display("FAIL wr_we_low_cycles: got %0d required 4", we_low);
    end
    checks++;
    if (lanes_bad != 0 || oe_low != 0) begin
      errors++; $display("FAIL wr_strobes: lane/ce errors %0d oe_low %0d required 0/0", lanes_bad, oe_low);
    end
    checks++;
    if (data_cnt != 5) begin
      errors++; $display("FAIL wr_data_cycles: got %0d required 5", data_cnt);
    end
    checks++;
    if (rsp_cnt != 1 || rsp_cyc != 5) begin
      errors++; $display("FAIL wr_rsp: got %0d pulses at cycle %0d required 1 at 5", rsp_cnt, rsp_cyc);
    end
    checks++;
    if (rdy_cyc != 6) begin
      errors++; $display("FAIL wr_ready_again: got cycle %0d required 6", rdy_cyc);
    end
    checks++;
    if (rsp_rdata !== 16'h0000) begin
      errors++; $display("FAIL wr_rdata_unchanged: got %h required 0000", rsp_rdata);
    end
  endtask

  task automatic test_read(input logic [15:0] exp);
    int oe_low = 0, lanes_bad = 0, we_low = 0, rsp_cyc = 0;
    logic [15:0] rd5 = 16'h0;
    logic [15:0] bus1 = 16'h0;
    start_req(1'b0, 24'h00_0123, 16'h0000, 2'b00);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 1) bus1 = mem_data;
      if (!mem_oe_n) begin
        oe_low++;
        if (mem_ub_n || mem_lb_n || mem_ce_n) lanes_bad++;
      end
      if (!mem_we_n) we_low++;
      if (rsp_valid && rsp_cyc == 0) begin rsp_cyc = c; rd5 = rsp_rdata; end
    end
    checks++;
    if (oe_low != 4 || lanes_bad != 0 || we_low != 0) begin
      errors++;
      $display("FAIL rd_strobes: oe_low %0d lane errs %0d we_low %0d required 4/0/0", oe_low, lanes_bad, we_low);
    end
    checks++;
    if (bus1 !== 16'hFFFF) begin
      errors++; $display("FAIL rd_bus_released: got %h required ffff", bus1);
    end
    checks++;
    if (rsp_cyc != 5 || rd5 !== exp) begin
      errors++; $display("FAIL rd_rsp: got cycle %0d data %h required 5 data %h", rsp_cyc, rd5, exp);
    end
  endtask

  task automatic test_byte_write();
    int lane_ok = 0, lane_bad = 0;
    start_req(1'b1, 24'h00_0123, 16'h1234, 2'b01);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (!mem_we_n) begin
        if (mem_ub_n === 1'b1 && mem_lb_n === 1'b0) lane_ok++;
        else lane_bad++;
      end
    end
    checks++;
    if (lane_ok != 4 || lane_bad != 0) begin
      errors++; $display("FAIL bw_lanes: ok %0d bad %0d required 4/0", lane_ok, lane_bad);
    end
    test_read(16'hBE34);
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int accepts = 0, rsp_cnt = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 24'h00_0123;
    req_be    = 2'b11;
    for (int c = 0; c < 30; c++) begin
      if (accepts == 3 && req_valid) req_valid = 1'b0;
      if (rsp_valid) rsp_cnt++;
      if (req_valid && req_ready) begin
        acc[accepts] = c + 1;
        accepts++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (accepts != 3) begin
      errors++; $display("FAIL b2b_accepts: got %0d required 3", accepts);
    end else begin
      checks++;
      if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
        errors++; $display("FAIL b2b_spacing: got %0d,%0d required 6,6", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    checks++;
    if (rsp_cnt != 3) begin
      errors++; $display("FAIL b2b_rsp_pulses: got %0d required 3", rsp_cnt);
    end
    checks++;
    if (rsp_rdata !== 16'hBE34) begin
      errors++; $display("FAIL b2b_rdata: got %h required be34", rsp_rdata);
    end
  endtask

  task automatic test_abort();
    int rsp_cnt = 0;
    start_req(1'b1, 24'h00_0040, 16'hDEAD, 2'b11);
    checks++;
    if (mem_we_n !== 1'b0) begin
      errors++; $display("FAIL abort_write_started: we_n=%b required 0", mem_we_n);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n} !== 5'b11111) begin
      errors++;
      $display("FAIL abort_strobes: got %b required 11111",
               {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n});
    end
    checks++;
    if (mem_data !== 16'hFFFF) begin
      errors++; $display("FAIL abort_bus_released: got %h required ffff", mem_data);
    end
    if (rsp_valid) rsp_cnt++;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_cnt++;
      if (c == 0) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL abort_ready: got %b required 1", req_ready);
        end
      end
    end
    checks++;
    if (rsp_cnt != 0) begin
      errors++; $display("FAIL abort_no_rsp: got %0d pulses required 0", rsp_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 24'h0;
    req_wdata = 16'h0;
    req_be    = 2'b00;
    mem_wait  = 1'b0;
    test_reset();
    test_write();
    test_read(16'hBEEF);
    test_byte_write();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
